// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shared pipeline constants and fetch FSM state type
package arm_pkg;

  localparam logic [31:0] NOP_INSTR = 32'hE1A0_0000;  // MOV r0,r0

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  function automatic logic [31:0] pc_plus4(input logic [31:0] a);
    return a + 32'd4;
  endfunction

endpackage

// File: rtl/if_register.sv
// rtl/if_register.sv - IF/ID pipeline register with load enable and flush-to-NOP
module if_register
  import arm_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        flush_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
);

  logic [31:0] instr_q;
  logic [31:0] pc_q;

  // Flush wins over load; a flush keeps the previous PC and only kills the instruction
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
    end else if (flush_i) begin
      instr_q <= NOP_INSTR;
    end else if (load_i) begin
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction fetch stage; IF_PERF_CNT_EN adds fetch/stall counters
module if_fetch_stage
  import arm_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hazard,
  input  logic        branchTaken,
  input  logic [31:0] branchAddress,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemReady,
  input  logic        imemValid,
  input  logic [31:0] imemData,
  output logic [31:0] instruction,
  output logic [31:0] PC
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetchCount,
  output logic [31:0] stallCount
`endif
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  fetch_addr_q, fetch_addr_d;
  logic [31:0]  hold_q, hold_d;
  logic         drop_q, drop_d;

  logic         req_c;
  logic         ifid_load;
  logic         ifid_flush;
  logic [31:0]  ifid_instr;
  logic [31:0]  ifid_pc;

  // Fetch state, program counter, hold buffer and drop flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= REQ;
      pc_q         <= RESET_PC;
      fetch_addr_q <= '0;
      hold_q       <= '0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fetch_addr_q <= fetch_addr_d;
      hold_q       <= hold_d;
      drop_q       <= drop_d;
    end
  end

  // Next state, memory request and IF/ID load selection; a redirect overrides everything
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fetch_addr_d = fetch_addr_q;
    hold_d       = hold_q;
    drop_d       = drop_q;
    req_c        = 1'b0;
    ifid_load    = 1'b0;
    ifid_flush   = 1'b0;
    ifid_instr   = NOP_INSTR;
    ifid_pc      = PC;
    if (branchTaken) begin
      ifid_flush = 1'b1;
      pc_d       = branchAddress;
      hold_d     = '0;
      // A response still owed by memory must be swallowed when it shows up
      if (state_q == WAIT && !imemValid) begin
        state_d = WAIT;
        drop_d  = 1'b1;
      end else begin
        state_d = REQ;
        drop_d  = 1'b0;
      end
    end else begin
      case (state_q)
        REQ: begin
          req_c     = 1'b1;
          ifid_load = !hazard;
          if (imemReady) begin
            state_d      = WAIT;
            fetch_addr_d = pc_q;
            pc_d         = pc_plus4(pc_q);
          end
        end
        WAIT: begin
          ifid_load = !hazard;
          if (imemValid) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = REQ;
            end else if (hazard) begin
              hold_d  = imemData;
              state_d = HOLD;
            end else begin
              ifid_instr = imemData;
              ifid_pc    = pc_plus4(fetch_addr_q);
              // Back-to-back: the next request goes out in the delivery cycle
              req_c      = 1'b1;
              if (imemReady) begin
                fetch_addr_d = pc_q;
                pc_d         = pc_plus4(pc_q);
              end else begin
                state_d = REQ;
              end
            end
          end
        end
        HOLD: begin
          if (!hazard) begin
            ifid_load  = 1'b1;
            ifid_instr = hold_q;
            ifid_pc    = pc_plus4(fetch_addr_q);
            state_d    = REQ;
          end
        end
        default: state_d = REQ;
      endcase
    end
  end

  assign imemReq  = req_c & rst;
  assign imemAddr = pc_q;

  if_register u_if_register (
    .clk     (clk),
    .rst     (rst),
    .load_i  (ifid_load),
    .flush_i (ifid_flush),
    .instr_i (ifid_instr),
    .pc_i    (ifid_pc),
    .instr_o (instruction),
    .pc_o    (PC)
  );

`ifdef IF_PERF_CNT_EN
  logic        deliver;
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;

  assign deliver = !branchTaken && !hazard &&
                   ((state_q == WAIT && imemValid && !drop_q) || state_q == HOLD);

  // Real instructions entering IF/ID and frozen cycles, both wrapping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (deliver) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (hazard)  stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign fetchCount = fetch_cnt_q;
  assign stallCount = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - randomized self-checking bench for if_fetch_stage
module tb_if_fetch_stage;
  import arm_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        hazard = 1'b0;
  logic        branchTaken = 1'b0;
  logic [31:0] branchAddress = '0;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemReady = 1'b0;
  logic        imemValid = 1'b0;
  logic [31:0] imemData = '0;
  logic [31:0] instruction;
  logic [31:0] PC;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetchCount;
  logic [31:0] stallCount;
`endif

  if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .hazard        (hazard),
    .branchTaken   (branchTaken),
    .branchAddress (branchAddress),
    .imemReq       (imemReq),
    .imemAddr      (imemAddr),
    .imemReady     (imemReady),
    .imemValid     (imemValid),
    .imemData      (imemData),
    .instruction   (instruction),
    .PC            (PC)
`ifdef IF_PERF_CNT_EN
    ,
    .fetchCount    (fetchCount),
    .stallCount    (stallCount)
`endif
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model: expected IF/ID contents, one parked word, the stream address
  // the next request must carry, and the single memory transaction in flight.
  logic [31:0] e_instr, e_pc, p_instr, p_pc, next_fetch, m_addr, e_fcnt, e_scnt;
  logic [31:0] stall_a, f0;
  bit          pend, m_busy, m_drop, br_done, br_flag, wrap_on;
  int          m_rem, wrap_k;

  logic [63:0] boot_tbl [3] = '{64'hC0DE0000_00000004, 64'hC0DE0004_00000008,
                                64'hC0DE0008_0000000C};

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    #12;
    chk("reset_instr", instruction, NOP_INSTR);
    chk("reset_pc", PC, 32'h0);
    chk("reset_req", {31'b0, imemReq}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    e_instr = NOP_INSTR; e_pc = '0; p_instr = '0; p_pc = '0;
    next_fetch = 32'h0; m_addr = '0; e_fcnt = '0; e_scnt = '0;
    stall_a = '0; f0 = '0;
    pend = 0; m_busy = 0; m_drop = 0; br_done = 0; br_flag = 0; wrap_on = 0;
    m_rem = 0; wrap_k = 0;

    for (int n = 0; n < 1560; n++) begin
      logic h, b, rdy, v, r, got;
      logic [31:0] ba, a, gw, ga;

      if (n > 0) begin
        chk("ifid_instr", instruction, e_instr);
        chk("ifid_pc", PC, e_pc);
`ifdef IF_PERF_CNT_EN
        chk("fetch_count", fetchCount, e_fcnt);
        chk("stall_count", stallCount, e_scnt);
`endif
        if (n >= 2 && n <= 4) begin
          chk("boot_instr", instruction, boot_tbl[n-2][63:32]);
          chk("boot_pc", PC, boot_tbl[n-2][31:0]);
        end
        if (n >= 5 && n <= 8) begin
          chk("hazard_hold_instr", instruction, 32'hC0DE_000C);
          chk("hazard_hold_pc", PC, 32'h0000_0010);
        end
        if (n == 9) begin
          chk("hazard_release_instr", instruction, 32'hC0DE_0010);
          chk("hazard_release_pc", PC, 32'h0000_0014);
        end
        if (br_flag && instruction !== NOP_INSTR) begin
          chk("redirect_instr", instruction, 32'hC0DE_0100);
          chk("redirect_pc", PC, 32'h0000_0104);
          br_flag = 0;
        end
        if (wrap_on && instruction !== NOP_INSTR) begin
          wrap_k++;
          if (wrap_k == 2) begin
            chk("wrap_instr", instruction, 32'h3F21_FFFC);
            chk("wrap_pc", PC, 32'h0000_0000);
            wrap_on = 0;
          end
        end
        if (n == 30) chk("redirect_seen", {31'b0, br_flag}, 32'h0);
        if (n == 50) begin
          chk("wrap_seen", {31'b0, wrap_on}, 32'h0);
          f0 = e_fcnt;
        end
      end

      // memory side: one response, a fixed number of cycles after acceptance
      v = 1'b0;
      if (m_busy) begin
        m_rem--;
        if (m_rem == 0) v = 1'b1;
      end

      h = 1'b0; b = 1'b0; ba = '0; rdy = 1'b1;
      if (n >= 5 && n <= 7) h = 1'b1;
      if (n >= 12 && n < 30 && !br_done && m_busy && !v && m_addr == 32'h20) begin
        b = 1'b1; ba = 32'h100; br_done = 1; br_flag = 1;
      end
      if (n >= 32 && n <= 35) rdy = 1'b0;
      if (n == 40) begin
        b = 1'b1; ba = 32'hFFFF_FFF8; wrap_on = 1; wrap_k = 0;
      end
      if (n >= 50) begin
        h   = ($urandom_range(0, 4) == 0);
        rdy = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 39) == 0) begin
          b  = 1'b1;
          ba = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'h0000_FFFC);
        end
      end

      hazard        = h;
      branchTaken   = b;
      branchAddress = ba;
      imemReady     = rdy;
      imemValid     = v;
      imemData      = v ? mem_word(m_addr) : $urandom;
      #1;
      r = imemReq;
      a = imemAddr;

      if (b) chk("no_req_on_branch", {31'b0, r}, 32'h0);
      else if (m_busy && !v) chk("single_outstanding", {31'b0, r}, 32'h0);
      if (r) chk("req_addr", a, next_fetch);
      if (n == 32) begin
        stall_a = a;
        chk("stall_req_first", {31'b0, r}, 32'h1);
      end
      if (n >= 33 && n <= 35) begin
        chk("stall_req", {31'b0, r}, 32'h1);
        chk("stall_addr", a, stall_a);
      end

      got = v && !m_drop;
      ga  = m_addr;
      gw  = mem_word(m_addr);
      if (v) begin
        m_busy = 0;
        m_drop = 0;
      end
      if (b) begin
        e_instr    = NOP_INSTR;
        pend       = 0;
        next_fetch = ba;
        if (m_busy) m_drop = 1;
      end else if (h) begin
        if (got) begin
          pend = 1; p_instr = gw; p_pc = ga + 32'd4;
        end
      end else if (got) begin
        e_instr = gw; e_pc = ga + 32'd4; e_fcnt++;
      end else if (pend) begin
        e_instr = p_instr; e_pc = p_pc; pend = 0; e_fcnt++;
      end else begin
        e_instr = NOP_INSTR;
      end
      if (h) e_scnt++;

      if (r && rdy && !b) begin
        m_busy = 1;
        m_drop = 0;
        m_addr = next_fetch;
        m_rem  = (n < 12 || (n >= 30 && n < 50)) ? 1 : ((n < 30) ? 3 : int'($urandom_range(1, 3)));
        next_fetch = next_fetch + 32'd4;
      end

      @(negedge clk);
    end

    chk("liveness", {31'b0, (e_fcnt - f0) > 32'd150}, 32'h1);

    hazard = 1'b0; branchTaken = 1'b0; imemReady = 1'b1; imemValid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("async_reset_instr", instruction, NOP_INSTR);
    chk("async_reset_pc", PC, 32'h0);
    chk("async_reset_req", {31'b0, imemReq}, 32'h0);
    #20;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
